gal_sop_olmc_cfg: RTL
=====================

Name: gal_sop_olmc_cfg

Overview:
- Behavioural simulation model of one GAL output path: a configurable sum-of-products array directly feeding an OLMC.
- Product-term fuses and OLMC mode bits (REGISTERED, INVERTED) are loaded at run time through a serial fuse-stream handshake rather than fixed by parameters.
- Used by the bench to check mapped SOP/OLMC netlists against fuse images before JEDEC emission.

Parameters:
- WIDTH, 2, number of SOP inputs A.
- DEPTH, 2, number of product terms.
- Derived NFUSE = 2*WIDTH*DEPTH + 2 (+2*DEPTH with feedback, see below).

Ports:
- C  input  1  clock; all state changes on rising edge.
- R  input  1  synchronous active-high reset.
- cfg_valid  input  1  fuse bit offered.
- cfg_bit  input  1  fuse value.
- cfg_last  input  1  marks final fuse of the image.
- cfg_ready  output  1  block accepts fuse bits.
- cfg_done  output  1  image loaded; block in RUN.
- cfg_err  output  1  one-cycle pulse on framing error.
- E  input  1  output enable.
- A  input  WIDTH  SOP inputs.
- Y  output  1  OLMC output value.
- Y_oe  output  1  tristate enable for Y.

Behaviour:
- States: UNCFG, LOAD, RUN.
- Reset (R=1 at edge, any state including mid-load):
  - state=UNCFG, fuse count=0, fuse array cleared to 0, register Q=0.
  - Outputs: cfg_done=0, cfg_err=0, Y=0, Y_oe=0; cfg_ready=1 from the first cycle after reset.
- cfg_ready=1 in UNCFG and LOAD, 0 in RUN.
- A fuse is accepted when cfg_valid & cfg_ready at an edge; it is written at index = count, then count increments. The first accept moves UNCFG to LOAD.
- Fuse ordering:
  - Index k = t*2*WIDTH + 2*i + p, where t = term, i = input, p=0 complement literal, p=1 true literal.
  - Index 2*WIDTH*DEPTH = REG; next index = INV.
- Framing:
  - cfg_last accepted with count = NFUSE-1: state goes to RUN and cfg_done=1 on the next cycle.
  - cfg_last accepted with count < NFUSE-1, or final fuse accepted without cfg_last: cfg_err pulses for 1 cycle, array is cleared, count=0, state returns to UNCFG.
- cfg_valid in RUN is ignored. RUN is exited only by R.
- SOP evaluation:
  - Each term is the AND of the literals whose fuse bit = 1.
  - A term with no fuses set = 1; a term with both polarities of any input set = 0.
  - S = OR of all terms. DEPTH terms all 0 gives S=0.
- OLMC in RUN:
  - Q <= S every edge.
  - Y = (REG ? Q : S) ^ INV, combinational from A when REG=0; one-cycle latency when REG=1.
  - Y_oe = E.
- Outside RUN: Y=0, Y_oe=0, Q held at 0.

Optional Feature:
- Macro GAL_OLMC_FEEDBACK_EN.
- Defined:
  - Q (REG=1) or Y (REG=0) is fed back as an extra SOP input with index i=WIDTH, so each term gets 2*(WIDTH+1) fuses and NFUSE = 2*(WIDTH+1)*DEPTH + 2.
  - The combinational loop for REG=0 with the feedback literal used is a configuration error: cfg_err pulses on cfg_last and the block returns to UNCFG.
- Undefined: no feedback input; NFUSE = 2*WIDTH*DEPTH + 2.

Test Plan:
- XOR, WIDTH=2, DEPTH=2, stream k0..9 = 0,1,1,0,1,0,0,1,0,0 with cfg_last on k9 -> cfg_done=1 next cycle, cfg_ready=0; A=01 gives Y=1, A=11 gives Y=0, A=10 gives Y=1, same cycle; E=0 gives Y_oe=0.
- Same image with REG=1, INV=1 -> A=01 applied: Y=0 after the next edge; A=00: Y=1 after the next edge; Y holds between edges.
- Early cfg_last on the 6th fuse -> cfg_err=1 for exactly 1 cycle, cfg_ready=1, cfg_done=0; a subsequent full valid image loads correctly.
- R asserted after 7 accepted fuses -> next cycle count=0, cfg_ready=1, Y_oe=0; a full reload gives a working XOR.
- cfg_valid toggling with gaps (valid low 3 cycles between bits) -> identical result to a back-to-back load; cfg_valid=1 in RUN leaves the fuses unchanged.
- With GAL_OLMC_FEEDBACK_EN, WIDTH=0, DEPTH=1, fuses = {FB complement=1, FB true=0, REG=1, INV=0} -> Y toggles 0,1,0,1 on successive edges after cfg_done.

Source files
------------

// File: rtl/gal_sop_olmc_cfg.sv
// ---------------------------------------------------------------------------
// gal_sop_olmc_cfg
//
// Behavioural model of one GAL output path. A sum-of-products array feeds an
// output logic macrocell (OLMC). The product-term fuses and the two OLMC mode
// bits (REG, INV) are loaded at run time from a serial fuse stream.
//
// Optional build macro: GAL_OLMC_FEEDBACK_EN
//   When defined, the macrocell output is routed back into the array as an
//   extra SOP input with index WIDTH. Each term then carries
//   2*(WIDTH+1) fuses. An image that uses this feedback literal while
//   REG=0 would form a combinational loop, so the loader rejects it with a
//   framing error.
//
// Parameters:
//   WIDTH      number of SOP inputs on A
//   DEPTH      number of product terms
//
// Ports:
//   C          clock; all state changes on the rising edge
//   R          synchronous active-high reset
//   cfg_valid  a fuse bit is offered on cfg_bit
//   cfg_bit    fuse value
//   cfg_last   marks the final fuse of the image
//   cfg_ready  high while the block accepts fuse bits (UNCFG, LOAD)
//   cfg_done   high once an image is loaded (RUN)
//   cfg_err    one-cycle pulse after a framing or configuration error
//   E          output enable, passed to Y_oe in RUN
//   A          SOP inputs
//   Y          macrocell output value
//   Y_oe       tristate enable for Y
//
// Fuse order in the stream:
//   index t*2*NIN + 2*i + p   term t, input i, p=0 complement, p=1 true
//   index 2*NIN*DEPTH         REG
//   index 2*NIN*DEPTH + 1     INV
// ---------------------------------------------------------------------------
module gal_sop_olmc_cfg #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic                                   C,
    input  logic                                   R,
    input  logic                                   cfg_valid,
    input  logic                                   cfg_bit,
    input  logic                                   cfg_last,
    output logic                                   cfg_ready,
    output logic                                   cfg_done,
    output logic                                   cfg_err,
    input  logic                                   E,
    input  logic [((WIDTH > 0) ? WIDTH : 1)-1:0]   A,
    output logic                                   Y,
    output logic                                   Y_oe
);

`ifdef GAL_OLMC_FEEDBACK_EN
    localparam int NIN = WIDTH + 1;
`else
    localparam int NIN = WIDTH;
`endif
    localparam int TF      = 2 * NIN;
    localparam int NSOP    = TF * DEPTH;
    localparam int NFUSE   = NSOP + 2;
    localparam int REG_IDX = NSOP;
    localparam int INV_IDX = NSOP + 1;
    localparam int CW      = $clog2(NFUSE + 1);
    localparam int XW      = (NIN > 0) ? NIN : 1;

    typedef enum logic [1:0] {
        S_UNCFG = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [NFUSE-1:0]   r_fuse;
    logic [CW-1:0]      r_count;
    logic               r_q;
    logic               r_err;

    logic [XW-1:0]      w_x;
    logic [DEPTH-1:0]   w_term;
    logic               w_s;
    logic               w_acc;
    logic               w_at_end;
    logic               w_loop_err;
    logic               w_load_ok;
    logic               w_frame_err;

    // Gather the array inputs. The feedback literal always comes from Q:
    // with REG=1 that is exactly what the macrocell feeds back, and with
    // REG=0 the loader refuses any image that uses the literal, so the value
    // on that input can never reach S.
    always_comb begin
        w_x = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_x[i] = A[i];
        end
`ifdef GAL_OLMC_FEEDBACK_EN
        w_x[WIDTH] = r_q;
`endif
    end

    // Product terms: a blown fuse kills the term whenever its literal is
    // false, so an empty term stays 1 and a term holding both polarities of
    // one input is always 0.
    always_comb begin
        w_term = '1;
        for (int t = 0; t < DEPTH; t++) begin
            for (int i = 0; i < NIN; i++) begin
                if (r_fuse[t*TF + 2*i] && w_x[i]) begin
                    w_term[t] = 1'b0;
                end
                if (r_fuse[t*TF + 2*i + 1] && !w_x[i]) begin
                    w_term[t] = 1'b0;
                end
            end
        end
    end

    assign w_s = |w_term;

    // A combinational macrocell that also uses its own output as a literal
    // would oscillate, so such an image counts as a configuration error.
    always_comb begin
        w_loop_err = 1'b0;
`ifdef GAL_OLMC_FEEDBACK_EN
        if (!r_fuse[REG_IDX]) begin
            for (int t = 0; t < DEPTH; t++) begin
                if (r_fuse[t*TF + 2*WIDTH] || r_fuse[t*TF + 2*WIDTH + 1]) begin
                    w_loop_err = 1'b1;
                end
            end
        end
`endif
    end

    // Framing: the image is good only when cfg_last coincides with the final
    // fuse slot. Last-too-early and final-without-last are both errors.
    assign w_acc       = cfg_valid && (r_state != S_RUN);
    assign w_at_end    = (r_count == CW'(NFUSE - 1));
    assign w_load_ok   = w_acc && cfg_last && w_at_end && !w_loop_err;
    assign w_frame_err = w_acc && ((cfg_last != w_at_end) || (cfg_last && w_loop_err));

    // State register.
    always_ff @(posedge C) begin
        if (R) begin
            r_state <= S_UNCFG;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode. Outside RUN the macrocell is silent.
    always_comb begin
        w_next    = r_state;
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        Y         = 1'b0;
        Y_oe      = 1'b0;
        case (r_state)
            S_UNCFG, S_LOAD: begin
                cfg_ready = 1'b1;
                if (w_frame_err) begin
                    w_next = S_UNCFG;
                end else if (w_load_ok) begin
                    w_next = S_RUN;
                end else if (w_acc) begin
                    w_next = S_LOAD;
                end
            end
            S_RUN: begin
                cfg_done = 1'b1;
                Y        = (r_fuse[REG_IDX] ? r_q : w_s) ^ r_fuse[INV_IDX];
                Y_oe     = E;
            end
            default: begin
                w_next = S_UNCFG;
            end
        endcase
    end

    // Fuse array, stream counter, error pulse and the macrocell register.
    // An error wipes the partial image so the next load starts from scratch.
    always_ff @(posedge C) begin
        if (R) begin
            r_fuse  <= '0;
            r_count <= '0;
            r_q     <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_frame_err;
            r_q   <= (r_state == S_RUN) ? w_s : 1'b0;
            if (w_frame_err) begin
                r_fuse  <= '0;
                r_count <= '0;
            end else if (w_acc) begin
                for (int k = 0; k < NFUSE; k++) begin
                    if (r_count == CW'(k)) begin
                        r_fuse[k] <= cfg_bit;
                    end
                end
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign cfg_err = r_err;

endmodule
